// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of TotalALU: latches one op, drives the ALU, returns 1 beat (2 for MULTU HI/LO).
// Latency: result valid ALU_LAT+1 edges after acceptance; MULTU first beat MUL_LAT+3 edges after.
// Backpressure: result beats hold while out_ready is low; in_ready only rises again in IDLE.
module alu_issue_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_funct,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [5:0]  alu_signal,
    output logic [31:0] alu_dataA,
    output logic [31:0] alu_dataB,
    output logic        alu_reset,
    input  logic [31:0] alu_output,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_last,
    output logic        out_err,
    output logic        busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CLR      = 3'd1;
    localparam logic [2:0] EXEC     = 3'd2;
    localparam logic [2:0] MFHI     = 3'd3;
    localparam logic [2:0] MFLO     = 3'd4;
    localparam logic [2:0] RESP_HI  = 3'd5;
    localparam logic [2:0] RESP     = 3'd6;
    localparam logic [2:0] RESP_ERR = 3'd7;

    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;

    localparam logic [CNT_W-1:0] ALU_LD = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             accept;
    logic             supported;

    assign in_ready  = (state == IDLE) && !reset;
    assign accept    = in_valid && in_ready;
    assign alu_reset = reset || (state == CLR);
    assign busy      = (state != IDLE);

    always_comb begin
        supported = 1'b0;
        case (in_funct)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_MULTU: supported = 1'b1;
            default: supported = 1'b0;
        endcase
    end

    // alu_signal doubles as the latched funct until the MULTU readout overwrites it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            alu_signal <= '0;
            alu_dataA  <= '0;
            alu_dataB  <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (supported) begin
                            alu_signal <= in_funct;
                            alu_dataA  <= in_a;
                            alu_dataB  <= in_b;
                            state      <= CLR;
                        end else begin
                            out_valid  <= 1'b1;
                            out_err    <= 1'b1;
                            out_last   <= 1'b1;
                            out_result <= '0;
                            state      <= RESP_ERR;
                        end
                    end
                end
                CLR: begin
                    cnt   <= (alu_signal == F_MULTU) ? MUL_LD : ALU_LD;
                    state <= EXEC;
                end
                EXEC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        if (alu_signal == F_MULTU) begin
                            alu_signal <= F_MFHI;
                            state      <= MFHI;
                        end else begin
                            out_result <= alu_output;
                            out_last   <= 1'b1;
                            out_valid  <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                MFHI: begin
                    hi_q       <= alu_output;
                    alu_signal <= F_MFLO;
                    state      <= MFLO;
                end
                MFLO: begin
                    lo_q       <= alu_output;
                    out_result <= hi_q;
                    out_last   <= 1'b0;
                    out_valid  <= 1'b1;
                    state      <= RESP_HI;
                end
                RESP_HI: begin
                    if (out_ready) begin
                        out_result <= lo_q;
                        out_last   <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                RESP_ERR: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
